// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the Ibex instruction fetch path.
package ibex_pkg;
  typedef enum logic [1:0] {EMPTY, STASHED, SKIP} realign_state_e;
endpackage

// File: rtl/ibex_instr_realign.sv
// ibex_instr_realign: splits word-aligned fetch data into 16/32-bit instructions
// with their PCs, carrying a halfword across word boundaries.
module ibex_instr_realign
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] boot_addr_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic        fetch_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_compressed_o,
  output logic        out_err_o
);
  realign_state_e r_state, w_state_n;
  logic [15:0] r_stash, w_stash_n;
  logic        r_stash_err, w_stash_err_n;
  logic [31:0] r_pc;
  logic        w_valid, w_take, w_err;
  logic [31:0] w_rdata;
  logic [15:0] w_lo, w_hi;
  logic        w_lo_c, w_hi_c, w_st_c;
  assign w_lo   = fetch_rdata_i[15:0];
  assign w_hi   = fetch_rdata_i[31:16];
  assign w_lo_c = w_lo[1:0] != 2'b11;
  assign w_hi_c = w_hi[1:0] != 2'b11;
  assign w_st_c = r_stash[1:0] != 2'b11;
  // Transitions use raw handshakes; branch and reset override them in the register block.
  always_comb begin
    w_state_n     = r_state;
    w_stash_n     = r_stash;
    w_stash_err_n = r_stash_err;
    w_valid       = 1'b0;
    w_take        = 1'b0;
    w_rdata       = fetch_rdata_i;
    w_err         = fetch_err_i;
    case (r_state)
      STASHED: begin
        if (w_st_c) begin
          w_valid = 1'b1;
          w_rdata = {16'h0, r_stash};
          w_err   = r_stash_err;
          if (out_ready_i) w_state_n = EMPTY;
        end else begin
          w_valid = fetch_valid_i;
          w_rdata = {w_lo, r_stash};
          w_err   = r_stash_err | fetch_err_i;
          if (fetch_valid_i && out_ready_i) begin
            w_take        = 1'b1;
            w_stash_n     = w_hi;
            w_stash_err_n = fetch_err_i;
          end
        end
      end
      SKIP: begin
        if (w_hi_c) begin
          w_valid = fetch_valid_i;
          w_rdata = {16'h0, w_hi};
          if (fetch_valid_i && out_ready_i) begin
            w_take    = 1'b1;
            w_state_n = EMPTY;
          end
        end else if (fetch_valid_i) begin
          w_take        = 1'b1;
          w_stash_n     = w_hi;
          w_stash_err_n = fetch_err_i;
          w_state_n     = STASHED;
        end
      end
      default: begin
        w_valid = fetch_valid_i;
        w_rdata = w_lo_c ? {16'h0, w_lo} : fetch_rdata_i;
        if (fetch_valid_i && out_ready_i) begin
          w_take = 1'b1;
          if (w_lo_c) begin
            w_stash_n     = w_hi;
            w_stash_err_n = fetch_err_i;
            w_state_n     = STASHED;
          end
        end
      end
    endcase
  end
  assign out_valid_o      = w_valid && !branch_i && !rst_i;
  assign fetch_ready_o    = !rst_i && (branch_i || w_take);
  assign out_rdata_o      = w_rdata;
  assign out_addr_o       = r_pc;
  assign out_compressed_o = w_rdata[1:0] != 2'b11;
  assign out_err_o        = w_err;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= EMPTY;
      r_stash     <= 16'h0;
      r_stash_err <= 1'b0;
      r_pc        <= boot_addr_i & ~32'h3;
    end else if (branch_i) begin
      r_state     <= branch_addr_i[1] ? SKIP : EMPTY;
      r_stash     <= 16'h0;
      r_stash_err <= 1'b0;
      r_pc        <= branch_addr_i & ~32'h1;
    end else begin
      r_state     <= w_state_n;
      r_stash     <= w_stash_n;
      r_stash_err <= w_stash_err_n;
      if (out_valid_o && out_ready_i) r_pc <= r_pc + (out_compressed_o ? 32'd2 : 32'd4);
    end
  end
endmodule

// File: tb/tb_ibex_instr_realign.sv
// tb_ibex_instr_realign: directed checks of realignment, branching, errors and reset.
module tb_ibex_instr_realign;
  logic        clk = 1'b0;
  logic        rst_i, branch_i, fetch_valid_i, fetch_err_i, out_ready_i;
  logic [31:0] boot_addr_i, branch_addr_i, fetch_rdata_i;
  logic        fetch_ready_o, out_valid_o, out_compressed_o, out_err_o;
  logic [31:0] out_rdata_o, out_addr_o;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ibex_instr_realign dut (
    .clk_i(clk), .rst_i(rst_i), .boot_addr_i(boot_addr_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .fetch_valid_i(fetch_valid_i), .fetch_rdata_i(fetch_rdata_i),
    .fetch_err_i(fetch_err_i), .fetch_ready_o(fetch_ready_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_rdata_o(out_rdata_o), .out_addr_o(out_addr_o),
    .out_compressed_o(out_compressed_o), .out_err_o(out_err_o)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] d, input logic e, input logic r);
    fetch_valid_i = v;
    fetch_rdata_i = d;
    fetch_err_i   = e;
    out_ready_i   = r;
    #1;
  endtask
  task automatic do_reset(input logic [31:0] boot);
    rst_i = 1'b1;
    branch_i = 1'b0;
    boot_addr_i = boot;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    cyc();
    rst_i = 1'b0;
  endtask
  task automatic test_reset();
    rst_i = 1'b1;
    boot_addr_i = 32'h103;
    branch_i = 1'b1;
    branch_addr_i = 32'h500;
    drive(1'b1, 32'h00000513, 1'b0, 1'b1);
    checks++;
    if (out_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b ready=%b required 0 0", out_valid_o, fetch_ready_o);
    end
    cyc();
    cyc();
    rst_i = 1'b0;
    branch_i = 1'b0;
    drive(1'b1, 32'h00000513, 1'b0, 1'b1);
    checks++;
    if (out_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL reset_pc got %h required 00000100", out_addr_o);
    end
  endtask
  task automatic test_aligned();
    do_reset(32'h100);
    drive(1'b1, 32'h00000513, 1'b0, 1'b1);
    checks++;
    if ({out_valid_o, out_compressed_o, fetch_ready_o} !== 3'b101 || out_rdata_o !== 32'h00000513 || out_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL aligned v/c/fr=%b%b%b data=%h addr=%h required 101 00000513 00000100",
               out_valid_o, out_compressed_o, fetch_ready_o, out_rdata_o, out_addr_o);
    end
    cyc();
    checks++;
    if (out_addr_o !== 32'h104) begin
      errors++;
      $display("FAIL aligned_pc_inc got %h required 00000104", out_addr_o);
    end
  endtask
  task automatic test_compressed_pair();
    do_reset(32'h100);
    drive(1'b1, 32'h45014501, 1'b0, 1'b1);
    checks++;
    if ({out_valid_o, out_compressed_o, fetch_ready_o} !== 3'b111 || out_rdata_o !== 32'h4501 || out_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL pair_first v/c/fr=%b%b%b data=%h addr=%h required 111 00004501 00000100",
               out_valid_o, out_compressed_o, fetch_ready_o, out_rdata_o, out_addr_o);
    end
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if ({out_valid_o, fetch_ready_o} !== 2'b10 || out_rdata_o !== 32'h4501 || out_addr_o !== 32'h102) begin
      errors++;
      $display("FAIL pair_second v/fr=%b%b data=%h addr=%h required 10 00004501 00000102",
               out_valid_o, fetch_ready_o, out_rdata_o, out_addr_o);
    end
    cyc();
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL pair_drained valid=%b required 0", out_valid_o);
    end
  endtask
  task automatic test_misaligned();
    do_reset(32'h100);
    drive(1'b1, 32'h05134501, 1'b0, 1'b1);
    checks++;
    if (out_rdata_o !== 32'h4501 || out_addr_o !== 32'h100 || fetch_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL span_first data=%h addr=%h fr=%b required 00004501 00000100 1", out_rdata_o, out_addr_o, fetch_ready_o);
    end
    cyc();
    drive(1'b1, 32'h00130000, 1'b0, 1'b0);
    checks++;
    if ({out_valid_o, fetch_ready_o} !== 2'b10 || out_rdata_o !== 32'h00000513) begin
      errors++;
      $display("FAIL span_stall v/fr=%b%b data=%h required 10 00000513", out_valid_o, fetch_ready_o, out_rdata_o);
    end
    cyc();
    checks++;
    if (out_valid_o !== 1'b1 || out_rdata_o !== 32'h00000513 || out_addr_o !== 32'h102) begin
      errors++;
      $display("FAIL span_stable v=%b data=%h addr=%h required 1 00000513 00000102", out_valid_o, out_rdata_o, out_addr_o);
    end
    drive(1'b1, 32'h00130000, 1'b0, 1'b1);
    checks++;
    if ({out_valid_o, out_compressed_o, fetch_ready_o} !== 3'b101 || out_rdata_o !== 32'h00000513 || out_addr_o !== 32'h102) begin
      errors++;
      $display("FAIL span_second v/c/fr=%b%b%b data=%h addr=%h required 101 00000513 00000102",
               out_valid_o, out_compressed_o, fetch_ready_o, out_rdata_o, out_addr_o);
    end
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (out_valid_o !== 1'b0 || out_addr_o !== 32'h106) begin
      errors++;
      $display("FAIL span_wait v=%b addr=%h required 0 00000106", out_valid_o, out_addr_o);
    end
  endtask
  task automatic test_branch();
    do_reset(32'h100);
    branch_i = 1'b1;
    branch_addr_i = 32'h207;
    drive(1'b1, 32'h00000513, 1'b0, 1'b1);
    checks++;
    if ({out_valid_o, fetch_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL branch_drop v/fr=%b%b required 01", out_valid_o, fetch_ready_o);
    end
    cyc();
    branch_i = 1'b0;
    drive(1'b1, 32'h4501abcd, 1'b0, 1'b1);
    checks++;
    if ({out_valid_o, out_compressed_o, fetch_ready_o} !== 3'b111 || out_rdata_o !== 32'h4501 || out_addr_o !== 32'h206) begin
      errors++;
      $display("FAIL branch_skip v/c/fr=%b%b%b data=%h addr=%h required 111 00004501 00000206",
               out_valid_o, out_compressed_o, fetch_ready_o, out_rdata_o, out_addr_o);
    end
    cyc();
    drive(1'b1, 32'h00000513, 1'b0, 1'b1);
    checks++;
    if (out_rdata_o !== 32'h00000513 || out_addr_o !== 32'h208) begin
      errors++;
      $display("FAIL branch_empty data=%h addr=%h required 00000513 00000208", out_rdata_o, out_addr_o);
    end
    cyc();
    branch_i = 1'b1;
    branch_addr_i = 32'h302;
    drive(1'b1, 32'h0, 1'b0, 1'b1);
    cyc();
    branch_i = 1'b0;
    drive(1'b1, 32'h05131234, 1'b0, 1'b0);
    checks++;
    if ({out_valid_o, fetch_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL skip_stash v/fr=%b%b required 01", out_valid_o, fetch_ready_o);
    end
    cyc();
    drive(1'b1, 32'h00130000, 1'b0, 1'b1);
    checks++;
    if (out_valid_o !== 1'b1 || out_rdata_o !== 32'h00000513 || out_addr_o !== 32'h302) begin
      errors++;
      $display("FAIL skip_span v=%b data=%h addr=%h required 1 00000513 00000302", out_valid_o, out_rdata_o, out_addr_o);
    end
  endtask
  task automatic test_simultaneous();
    do_reset(32'h100);
    branch_i = 1'b1;
    branch_addr_i = 32'h400;
    drive(1'b1, 32'h00000513, 1'b0, 1'b1);
    checks++;
    if ({out_valid_o, fetch_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL branch_vs_hs v/fr=%b%b required 01", out_valid_o, fetch_ready_o);
    end
    cyc();
    branch_i = 1'b0;
    drive(1'b1, 32'h00000513, 1'b0, 1'b1);
    checks++;
    if (out_addr_o !== 32'h400) begin
      errors++;
      $display("FAIL branch_vs_hs_pc got %h required 00000400", out_addr_o);
    end
  endtask
  task automatic test_wrap();
    do_reset(32'h100);
    branch_i = 1'b1;
    branch_addr_i = 32'hfffffffe;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    cyc();
    branch_i = 1'b0;
    drive(1'b1, 32'h45010000, 1'b0, 1'b1);
    checks++;
    if (out_rdata_o !== 32'h4501 || out_addr_o !== 32'hfffffffe) begin
      errors++;
      $display("FAIL wrap_top data=%h addr=%h required 00004501 fffffffe", out_rdata_o, out_addr_o);
    end
    cyc();
    drive(1'b1, 32'h00000513, 1'b0, 1'b1);
    checks++;
    if (out_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_zero addr=%h required 00000000", out_addr_o);
    end
  endtask
  task automatic test_error();
    do_reset(32'h100);
    drive(1'b1, 32'h05134501, 1'b0, 1'b1);
    checks++;
    if (out_err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clean got %b required 0", out_err_o);
    end
    cyc();
    drive(1'b1, 32'h00130000, 1'b1, 1'b1);
    checks++;
    if (out_valid_o !== 1'b1 || out_err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_second_word v=%b err=%b required 1 1", out_valid_o, out_err_o);
    end
    do_reset(32'h100);
    drive(1'b1, 32'h45014501, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 32'h00000513, 1'b0, 1'b1);
    checks++;
    if (out_rdata_o !== 32'h4501 || out_err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_stash_c data=%h err=%b required 00004501 1", out_rdata_o, out_err_o);
    end
  endtask
  task automatic test_reset_mid_stashed();
    do_reset(32'h100);
    drive(1'b1, 32'h05134501, 1'b0, 1'b1);
    cyc();
    rst_i = 1'b1;
    boot_addr_i = 32'h182;
    drive(1'b1, 32'h00130000, 1'b0, 1'b1);
    checks++;
    if ({out_valid_o, fetch_ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid v/fr=%b%b required 00", out_valid_o, fetch_ready_o);
    end
    cyc();
    rst_i = 1'b0;
    drive(1'b1, 32'h00000513, 1'b0, 1'b1);
    checks++;
    if (out_valid_o !== 1'b1 || out_rdata_o !== 32'h00000513 || out_addr_o !== 32'h180) begin
      errors++;
      $display("FAIL rst_mid_after v=%b data=%h addr=%h required 1 00000513 00000180", out_valid_o, out_rdata_o, out_addr_o);
    end
  endtask
  initial begin
    rst_i = 1'b1;
    boot_addr_i = 32'h0;
    branch_i = 1'b0;
    branch_addr_i = 32'h0;
    fetch_valid_i = 1'b0;
    fetch_rdata_i = 32'h0;
    fetch_err_i = 1'b0;
    out_ready_i = 1'b0;
    cyc();
    test_reset();
    test_aligned();
    test_compressed_pair();
    test_misaligned();
    test_branch();
    test_simultaneous();
    test_wrap();
    test_error();
    test_reset_mid_stashed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
